// File: rtl/i2c_master_reader_if.sv
// Host/bus signal bundle for the I2C read initiator.
// The master modport is the initiator's view; the slave modport is the
// view of whatever sits on the other side (host logic, bus model).
interface i2c_master_reader_if;
    logic       i_start;
    logic [6:0] i_slave_addr;
    logic [7:0] i_byte_count;
    logic       i_scl_in;
    logic       i_sda_in;
    logic       o_scl_out;
    logic       o_sda_out;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_nack_err;

    modport master (
        input  i_start, i_slave_addr, i_byte_count, i_scl_in, i_sda_in,
        output o_scl_out, o_sda_out, o_rx_data, o_rx_valid, o_busy, o_done, o_nack_err
    );

    modport slave (
        output i_start, i_slave_addr, i_byte_count, i_scl_in, i_sda_in,
        input  o_scl_out, o_sda_out, o_rx_data, o_rx_valid, o_busy, o_done, o_nack_err
    );
endinterface

// File: rtl/i2c_master_reader.sv
// I2C read initiator: START, {addr,R}, N data bytes (ACK all but the last,
// NACK the last), STOP. Every bus step is one SCL quarter of QDIV clocks;
// a bit slot is four quarters with SCL low in Q0/Q1 and released in Q2/Q3.
// SCL/SDA drive values are registered and computed from the state being
// entered, so SDA only moves on a quarter boundary.
module i2c_master_reader #(
    parameter int QDIV = 4
) (
    input logic clk,
    input logic rst,
    i2c_master_reader_if.master bus
);

    localparam int QW = $clog2(QDIV);
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_RDATA, S_MACK, S_STOP
    } state_t;

    state_t        r_state, w_state;
    logic [QW-1:0] r_qcnt, w_qcnt;
    logic [1:0]    r_quarter, w_quarter;
    logic [2:0]    r_bitcnt, w_bitcnt;
    logic [7:0]    r_addr_byte, w_addr_byte;
    logic [7:0]    r_remaining, w_remaining;
    logic [7:0]    r_shift, w_shift;
    logic          r_ack, w_ack;
    logic          r_scl, w_scl;
    logic          r_sda, w_sda;
    logic [7:0]    r_rx_data, w_rx_data;
    logic          r_rx_valid, w_rx_valid;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_nack, w_nack;
    logic          w_stretch;
    logic          w_tick;

    // Next-state logic: quarter timing with clock stretch, the transfer sequence,
    // and the line levels for the quarter being entered.
    always_comb begin
        w_state     = r_state;
        w_qcnt      = r_qcnt;
        w_quarter   = r_quarter;
        w_bitcnt    = r_bitcnt;
        w_addr_byte = r_addr_byte;
        w_remaining = r_remaining;
        w_shift     = r_shift;
        w_ack       = r_ack;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_nack      = r_nack;
        w_scl       = 1'b1;
        w_sda       = 1'b1;
        w_tick      = 1'b0;

        w_stretch = !bus.i_scl_in &&
                    (((r_state inside {S_ADDR, S_AACK, S_RDATA, S_MACK}) && r_quarter[1]) ||
                     ((r_state == S_STOP) && (r_quarter == 2'd1)));

        if (r_state != S_IDLE && !w_stretch) begin
            if (r_qcnt == QLAST) begin
                w_qcnt = '0;
                w_tick = 1'b1;
            end else begin
                w_qcnt = r_qcnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (bus.i_start && bus.i_byte_count != 8'd0) begin
                    w_state     = S_START;
                    w_qcnt      = '0;
                    w_quarter   = 2'd0;
                    w_bitcnt    = 3'd0;
                    w_addr_byte = {bus.i_slave_addr, 1'b1};
                    w_remaining = bus.i_byte_count;
                    w_busy      = 1'b1;
                    w_nack      = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_quarter == 2'd0) begin
                        w_quarter = 2'd1;
                    end else begin
                        w_state   = S_ADDR;
                        w_quarter = 2'd0;
                        w_bitcnt  = 3'd0;
                    end
                end
            end
            S_ADDR, S_AACK, S_RDATA, S_MACK: begin
                if (w_tick) begin
                    if (r_quarter == 2'd2) begin
                        if (r_state == S_RDATA) w_shift = {r_shift[6:0], bus.i_sda_in};
                        if (r_state == S_AACK)  w_ack   = bus.i_sda_in;
                    end
                    if (r_quarter != 2'd3) begin
                        w_quarter = r_quarter + 2'd1;
                    end else begin
                        w_quarter = 2'd0;
                        case (r_state)
                            S_ADDR: begin
                                if (r_bitcnt == 3'd7) begin
                                    w_state  = S_AACK;
                                    w_bitcnt = 3'd0;
                                end else begin
                                    w_bitcnt = r_bitcnt + 3'd1;
                                end
                            end
                            S_AACK: begin
                                if (!r_ack) begin
                                    w_state  = S_RDATA;
                                    w_bitcnt = 3'd0;
                                end else begin
                                    w_nack  = 1'b1;
                                    w_state = S_STOP;
                                end
                            end
                            S_RDATA: begin
                                if (r_bitcnt == 3'd7) begin
                                    w_rx_data  = r_shift;
                                    w_rx_valid = 1'b1;
                                    w_state    = S_MACK;
                                    w_bitcnt   = 3'd0;
                                end else begin
                                    w_bitcnt = r_bitcnt + 3'd1;
                                end
                            end
                            default: begin
                                w_remaining = (r_remaining != 8'd0) ? r_remaining - 8'd1 : 8'd0;
                                w_state     = (r_remaining > 8'd1) ? S_RDATA : S_STOP;
                            end
                        endcase
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_quarter == 2'd2) begin
                        w_state   = S_IDLE;
                        w_quarter = 2'd0;
                        w_done    = 1'b1;
                        w_busy    = 1'b0;
                    end else begin
                        w_quarter = r_quarter + 2'd1;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        case (w_state)
            S_START: begin
                w_scl = 1'b1;
                w_sda = (w_quarter == 2'd0);
            end
            S_ADDR: begin
                w_scl = w_quarter[1];
                w_sda = w_addr_byte[3'd7 - w_bitcnt];
            end
            S_AACK, S_RDATA: begin
                w_scl = w_quarter[1];
                w_sda = 1'b1;
            end
            S_MACK: begin
                w_scl = w_quarter[1];
                w_sda = (w_remaining > 8'd1) ? 1'b0 : 1'b1;
            end
            S_STOP: begin
                w_scl = (w_quarter != 2'd0);
                w_sda = (w_quarter == 2'd2);
            end
            default: begin
                w_scl = 1'b1;
                w_sda = 1'b1;
            end
        endcase
    end

    // State and output registers; reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_qcnt      <= '0;
            r_quarter   <= 2'd0;
            r_bitcnt    <= 3'd0;
            r_addr_byte <= 8'd0;
            r_remaining <= 8'd0;
            r_shift     <= 8'd0;
            r_ack       <= 1'b0;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_qcnt      <= w_qcnt;
            r_quarter   <= w_quarter;
            r_bitcnt    <= w_bitcnt;
            r_addr_byte <= w_addr_byte;
            r_remaining <= w_remaining;
            r_shift     <= w_shift;
            r_ack       <= w_ack;
            r_scl       <= w_scl;
            r_sda       <= w_sda;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_nack      <= w_nack;
        end
    end

    assign bus.o_scl_out  = r_scl;
    assign bus.o_sda_out  = r_sda;
    assign bus.o_rx_data  = r_rx_data;
    assign bus.o_rx_valid = r_rx_valid;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
    assign bus.o_nack_err = r_nack;

endmodule

// File: tb/tb_i2c_master_reader.sv
// Bench for i2c_master_reader: two instances (QDIV=4 and QDIV=2), each with
// an event-driven I2C slave model that decodes START/STOP and SCL edges on
// the wired-AND lines, answers the address and serves data bytes.
module tb_i2c_master_reader;

    localparam int QD0 = 4;
    localparam int QD1 = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    i2c_master_reader_if bus0();
    i2c_master_reader_if bus1();

    logic [1:0]      hStart;
    logic [1:0][6:0] hAddr;
    logic [1:0][7:0] hCount;

    logic [1:0]      slvSda;
    int              holdCnt [2];
    logic [1:0]      slvAckAddr;
    logic [1:0]      stretchEn;
    logic [7:0]      slvData [2][256];

    logic [1:0]      sclLine, sdaLine;
    logic [1:0]      wSclOut, wSdaOut, wRxValid, wBusy, wDone, wNack;
    logic [1:0][7:0] wRxData;

    logic [1:0]      prevScl, prevSda, active, nacked;
    int              bitN [2];
    int              frameN [2];
    int              stopCount [2];
    logic [7:0]      shiftIn [2];
    logic [7:0]      seenAddr [2];
    logic            ackSeen [2][256];

    int checkCount = 0;
    int errorCount = 0;

    assign bus0.i_start      = hStart[0];
    assign bus0.i_slave_addr = hAddr[0];
    assign bus0.i_byte_count = hCount[0];
    assign bus0.i_scl_in     = sclLine[0];
    assign bus0.i_sda_in     = sdaLine[0];
    assign bus1.i_start      = hStart[1];
    assign bus1.i_slave_addr = hAddr[1];
    assign bus1.i_byte_count = hCount[1];
    assign bus1.i_scl_in     = sclLine[1];
    assign bus1.i_sda_in     = sdaLine[1];

    assign sclLine[0] = bus0.o_scl_out & (holdCnt[0] == 0);
    assign sdaLine[0] = bus0.o_sda_out & slvSda[0];
    assign sclLine[1] = bus1.o_scl_out & (holdCnt[1] == 0);
    assign sdaLine[1] = bus1.o_sda_out & slvSda[1];

    assign wSclOut  = {bus1.o_scl_out,  bus0.o_scl_out};
    assign wSdaOut  = {bus1.o_sda_out,  bus0.o_sda_out};
    assign wRxValid = {bus1.o_rx_valid, bus0.o_rx_valid};
    assign wBusy    = {bus1.o_busy,     bus0.o_busy};
    assign wDone    = {bus1.o_done,     bus0.o_done};
    assign wNack    = {bus1.o_nack_err, bus0.o_nack_err};
    assign wRxData[0] = bus0.o_rx_data;
    assign wRxData[1] = bus1.o_rx_data;

    i2c_master_reader #(.QDIV(QD0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    i2c_master_reader #(.QDIV(QD1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

    // Slave model: frame 0 is the address byte, frames 1.. are data bytes.
    // Bits are taken on SCL rising edges, the slave's SDA is set after SCL falls.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                prevScl[g] <= 1'b1;
                prevSda[g] <= 1'b1;
                active[g]  <= 1'b0;
                nacked[g]  <= 1'b0;
                bitN[g]    <= 0;
                frameN[g]  <= 0;
                slvSda[g]  <= 1'b1;
                holdCnt[g] <= 0;
            end else begin
                prevScl[g] <= sclLine[g];
                prevSda[g] <= sdaLine[g];
                if (holdCnt[g] > 0) holdCnt[g] <= holdCnt[g] - 1;
                if (prevScl[g] && sclLine[g] && prevSda[g] && !sdaLine[g]) begin
                    active[g] <= 1'b1;
                    nacked[g] <= 1'b0;
                    bitN[g]   <= 0;
                    frameN[g] <= 0;
                end else if (prevScl[g] && sclLine[g] && !prevSda[g] && sdaLine[g]) begin
                    active[g]    <= 1'b0;
                    stopCount[g] <= stopCount[g] + 1;
                    slvSda[g]    <= 1'b1;
                end else if (!prevScl[g] && sclLine[g] && active[g]) begin
                    if (frameN[g] == 0 && bitN[g] < 8) begin
                        shiftIn[g] <= {shiftIn[g][6:0], sdaLine[g]};
                        if (bitN[g] == 7) seenAddr[g] <= {shiftIn[g][6:0], sdaLine[g]};
                    end
                    if (frameN[g] > 0 && frameN[g] <= 256 && bitN[g] == 8) begin
                        ackSeen[g][frameN[g]-1] <= sdaLine[g];
                        if (sdaLine[g]) nacked[g] <= 1'b1;
                    end
                    if (bitN[g] == 8) begin
                        bitN[g]   <= 0;
                        frameN[g] <= frameN[g] + 1;
                    end else begin
                        bitN[g] <= bitN[g] + 1;
                    end
                end else if (prevScl[g] && !sclLine[g] && active[g]) begin
                    slvSda[g] <= 1'b1;
                    if (frameN[g] == 0 && bitN[g] == 8)
                        slvSda[g] <= !slvAckAddr[g];
                    else if (frameN[g] > 0 && frameN[g] <= 256 && bitN[g] < 8 && slvAckAddr[g] && !nacked[g])
                        slvSda[g] <= slvData[g][frameN[g]-1][7-bitN[g]];
                    if (stretchEn[g] && frameN[g] == 1 && bitN[g] == 3)
                        holdCnt[g] <= 2 * ((g == 0) ? QD0 : QD1) + 20;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete read on instance inst; expectations come from the protocol
    // arithmetic: 41 + 36*N quarters per transfer, N=0 if the address is refused.
    task automatic applyStimulus(input int inst, input logic [6:0] addr, input int n,
                                 input bit ackAddr, input bit stretch, input bit busyStart);
        int qd, expRx, expLat, k, doneK, rxN, stopBefore, quiet;
        bit doneSeen;
        logic [7:0] rxGot [256];
        qd     = (inst == 0) ? QD0 : QD1;
        expRx  = ackAddr ? n : 0;
        expLat = qd * (41 + 36 * expRx) + ((stretch && ackAddr) ? 20 : 0);
        slvAckAddr[inst] = ackAddr;
        stretchEn[inst]  = stretch;
        stopBefore = stopCount[inst];
        @(negedge clk);
        hStart[inst] = 1'b1;
        hAddr[inst]  = addr;
        hCount[inst] = 8'(n);
        @(negedge clk);
        hStart[inst] = 1'b0;
        hAddr[inst]  = ~addr;
        hCount[inst] = 8'($urandom_range(1, 255));
        checkOutput("busyStart", 32'(wBusy[inst]), 32'd1);
        k = 1; doneK = 0; rxN = 0; doneSeen = 1'b0;
        while (!doneSeen && k <= expLat + 200) begin
            if (wRxValid[inst] && rxN < 256) begin
                rxGot[rxN] = wRxData[inst];
                rxN++;
            end
            if (wDone[inst]) begin
                doneSeen = 1'b1;
                doneK = k;
            end else begin
                hStart[inst] = busyStart && (k == 60);
                if (busyStart && k == 60) begin
                    hAddr[inst]  = 7'h7F;
                    hCount[inst] = 8'd5;
                end
                @(negedge clk);
                k++;
            end
        end
        hStart[inst] = 1'b0;
        checkOutput("doneSeen", 32'(doneSeen), 32'd1);
        checkOutput("latency", 32'(doneK - 1), 32'(expLat));
        checkOutput("busyAtDone", 32'(wBusy[inst]), 32'd0);
        checkOutput("nackErr", 32'(wNack[inst]), 32'(!ackAddr));
        checkOutput("rxCount", 32'(rxN), 32'(expRx));
        for (int i = 0; i < rxN && i < expRx; i++)
            checkOutput("rxByte", 32'(rxGot[i]), 32'(slvData[inst][i]));
        checkOutput("addrByte", 32'(seenAddr[inst]), 32'({addr, 1'b1}));
        if (ackAddr)
            for (int i = 0; i < n; i++)
                checkOutput("masterAck", 32'(ackSeen[inst][i]), 32'(i == n - 1));
        @(negedge clk);
        checkOutput("donePulse", 32'(wDone[inst]), 32'd0);
        checkOutput("stopSeen", 32'(stopCount[inst] - stopBefore), 32'd1);
        if (expRx > 0) checkOutput("rxHeld", 32'(wRxData[inst]), 32'(slvData[inst][n-1]));
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (wBusy[inst] || wDone[inst]) quiet++;
        end
        checkOutput("idleQuiet", 32'(quiet), 32'd0);
    endtask

    initial begin
        int w, cnt, inst, n;
        bit ack;
        rst = 1'b1;
        hStart = '0;
        hAddr = '0;
        hCount = '0;
        slvAckAddr = '0;
        stretchEn = '0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) slvData[g][i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rstScl", 32'(wSclOut), 32'h3);
        checkOutput("rstSda", 32'(wSdaOut), 32'h3);
        checkOutput("rstBusy", 32'(wBusy | wDone | wRxValid | wNack), 32'h0);
        checkOutput("rstRxData", 32'(wRxData), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single byte read, addr 0x50");
        slvData[0][0] = 8'hA5;
        applyStimulus(0, 7'h50, 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] three byte read, addr 0x2A");
        slvData[0][0] = 8'h01; slvData[0][1] = 8'h80; slvData[0][2] = 8'hFF;
        applyStimulus(0, 7'h2A, 3, 1'b1, 1'b0, 1'b0);

        $display("[TB] address refused, then a normal read");
        applyStimulus(0, 7'h11, 2, 1'b0, 1'b0, 1'b0);
        slvData[0][0] = 8'($urandom);
        applyStimulus(0, 7'h12, 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] clock stretch of 20 clk in data bit 3");
        slvData[0][0] = 8'($urandom);
        applyStimulus(0, 7'h3C, 1, 1'b1, 1'b1, 1'b0);

        $display("[TB] start while busy is ignored");
        slvData[0][0] = 8'($urandom); slvData[0][1] = 8'($urandom);
        applyStimulus(0, 7'h66, 2, 1'b1, 1'b0, 1'b1);

        $display("[TB] start with zero byte count is ignored");
        @(negedge clk);
        hStart[0] = 1'b1; hAddr[0] = 7'h44; hCount[0] = 8'd0;
        @(negedge clk);
        hStart[0] = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (wBusy[0] || wDone[0]) cnt++;
        end
        checkOutput("zeroCount", 32'(cnt), 32'd0);

        $display("[TB] reset in the middle of the second data byte");
        slvData[0][0] = 8'h5C; slvData[0][1] = 8'hC3;
        slvAckAddr[0] = 1'b1; stretchEn[0] = 1'b0;
        @(negedge clk);
        hStart[0] = 1'b1; hAddr[0] = 7'h20; hCount[0] = 8'd2;
        @(negedge clk);
        hStart[0] = 1'b0;
        w = 0;
        while (!(frameN[0] == 2 && bitN[0] == 4) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checkOutput("reachBit4", 32'(w < 2000), 32'd1);
        checkOutput("rxBeforeRst", 32'(wRxData[0]), 32'h5C);
        rst = 1'b1;
        #1;
        checkOutput("midRstLines", 32'({wSclOut[0], wSdaOut[0]}), 32'h3);
        checkOutput("midRstFlags", 32'({wBusy[0], wDone[0], wRxValid[0], wNack[0]}), 32'h0);
        checkOutput("midRstRxData", 32'(wRxData[0]), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (wDone[0] || wBusy[0]) cnt++;
        end
        checkOutput("noDoneAfterRst", 32'(cnt), 32'd0);
        applyStimulus(0, 7'h20, 2, 1'b1, 1'b0, 1'b0);

        $display("[TB] QDIV=2 single byte read");
        slvData[1][0] = 8'hA5;
        applyStimulus(1, 7'h50, 1, 1'b1, 1'b0, 1'b0);

        $display("[TB] randomized transfers");
        repeat (6) begin
            inst = $urandom_range(0, 1);
            n    = $urandom_range(1, 4);
            ack  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) slvData[inst][i] = 8'($urandom);
            applyStimulus(inst, 7'($urandom), n, ack, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
